// File: rtl/atm_bank_responder_if.sv
// atm_bank_responder_if: request/response handshake bundle between an ATM and the bank responder
interface atm_bank_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_pin;
  logic [31:0] req_amount;
  logic        session_end;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_balance;
  logic        authenticated;
  logic        locked;
  modport master (
    output req_valid, req_op, req_pin, req_amount, session_end, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, authenticated, locked
  );
  modport slave (
    input  req_valid, req_op, req_pin, req_amount, session_end, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance, authenticated, locked
  );
endinterface

// File: rtl/atm_bank_responder.sv
// atm_bank_responder: single-account bank responder (IDLE/EXEC/RESP); optional lockout via macro ATM_LOCKOUT_EN
module atm_bank_responder #(
  parameter logic [31:0] INIT_BALANCE = 32'd1000,
  parameter logic [3:0]  STORED_PIN   = 4'b1010,
  parameter int unsigned MAX_TRIES    = 3
) (
  input logic clk,
  input logic reset,
  atm_bank_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [1:0] OP_PIN = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b10;
  localparam logic [1:0] OP_WD  = 2'b11;
  localparam logic [2:0] MAX_CNT = 3'(MAX_TRIES);
  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  pin_q, pin_d;
  logic [31:0] amount_q, amount_d;
  logic [31:0] balance_q, balance_d;
  logic        auth_q, auth_d;
  logic [2:0]  fail_q, fail_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rsp_bal_q, rsp_bal_d;
  logic [32:0] sum;
  logic        locked_q;
  assign bus.req_ready     = state_q == IDLE;
  assign bus.rsp_valid     = state_q == RESP;
  assign bus.rsp_status    = status_q;
  assign bus.rsp_balance   = rsp_bal_q;
  assign bus.authenticated = auth_q;
  assign bus.locked        = locked_q;
  assign sum = {1'b0, balance_q} + {1'b0, amount_q};
  // capture on accept, evaluate in EXEC, hold the response until taken; session_end always wins on auth
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pin_d     = pin_q;
    amount_d  = amount_q;
    balance_d = balance_q;
    auth_d    = auth_q;
    fail_d    = fail_q;
    status_d  = status_q;
    rsp_bal_d = rsp_bal_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d  = EXEC;
        op_d     = bus.req_op;
        pin_d    = bus.req_pin;
        amount_d = bus.req_amount;
      end
      EXEC: begin
        state_d = RESP;
        if (locked_q) status_d = 2'b11;
        else if (op_q == OP_PIN) begin
          status_d = pin_q == STORED_PIN ? 2'b00 : 2'b01;
          auth_d   = pin_q == STORED_PIN;
          fail_d   = pin_q == STORED_PIN ? 3'd0 : fail_q >= MAX_CNT ? fail_q : fail_q + 3'd1;
        end
        else if (!auth_q) status_d = 2'b11;
        else if ((op_q == OP_DEP && sum[32]) || (op_q == OP_WD && amount_q > balance_q)) status_d = 2'b10;
        else begin
          status_d  = 2'b00;
          balance_d = op_q == OP_DEP ? sum[31:0] : op_q == OP_WD ? balance_q - amount_q : balance_q;
        end
        rsp_bal_d = balance_d;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.session_end) auth_d = 1'b0;
  end
  // state and datapath registers; reset aborts any in-flight transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      pin_q     <= 4'b0000;
      amount_q  <= 32'd0;
      balance_q <= INIT_BALANCE;
      auth_q    <= 1'b0;
      fail_q    <= 3'd0;
      status_q  <= 2'b00;
      rsp_bal_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pin_q     <= pin_d;
      amount_q  <= amount_d;
      balance_q <= balance_d;
      auth_q    <= auth_d;
      fail_q    <= fail_d;
      status_q  <= status_d;
      rsp_bal_q <= rsp_bal_d;
    end
  end
`ifdef ATM_LOCKOUT_EN
  logic locked_d;
  // lock sticks once the consecutive-failure count reaches the limit
  always_comb begin
    locked_d = locked_q | (fail_d >= MAX_CNT);
  end
  // lockout register, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) locked_q <= 1'b0;
    else locked_q <= locked_d;
  end
`else
  assign locked_q = 1'b0;
`endif
endmodule
